per_copy_engine: RTL and testbench

- Memory-mapped peripheral-bus copy engine for the openMSP430 peripheral space.
- Software programs source address, destination address and word count, then starts the engine.
- The engine moves words from source peripheral registers to destination registers (e.g. the 0x110–0x115 register block) using bus cycles the CPU leaves idle.
- Sits between the CPU peripheral port and the downstream peripherals. It arbitrates the shared per_* bus; the CPU always has absolute priority because the CPU bus cannot be stalled.

---
 rtl/per_copy_engine.sv | 164 ++++++++++++++++
 tb/tb_per_copy_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/per_copy_engine.sv
// Peripheral-bus copy engine: moves CNT words from SRC to DST using idle per_* bus cycles.
// CPU accesses always win the downstream bus; engine registers sit at BASE_ADDR..BASE_ADDR+3.
module per_copy_engine #(
    parameter logic [13:0] BASE_ADDR = 14'h8C
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [13:0] m_addr,
    output logic [15:0] m_din,
    output logic        m_en,
    output logic [1:0]  m_we,
    input  logic [15:0] m_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t      state, state_nxt;
    logic [15:0] src_reg, dst_reg, cnt_reg;
    logic [15:0] src_ptr, dst_ptr, data_q;
    logic        done, ie, busy;

    logic        sel_ctrl, sel_src, sel_dst, sel_cnt;
    logic        reg_wr, reg_rd, ctrl_wr, start_req, abort_req;
    logic        load, latch, advance, set_done;
    logic        eng_en;
    logic [1:0]  eng_we;
    logic [13:0] eng_addr;
    logic [15:0] eng_din;

    assign sel_ctrl  = (per_addr == BASE_ADDR);
    assign sel_src   = (per_addr == BASE_ADDR + 14'd1);
    assign sel_dst   = (per_addr == BASE_ADDR + 14'd2);
    assign sel_cnt   = (per_addr == BASE_ADDR + 14'd3);
    assign reg_wr    = per_en && (per_we == 2'b11);
    assign reg_rd    = per_en && (per_we == 2'b00);
    assign busy      = (state != ST_IDLE);
    assign ctrl_wr   = reg_wr && sel_ctrl;
    assign abort_req = ctrl_wr && per_din[4];
    assign start_req = ctrl_wr && per_din[0] && !busy;
    assign irq       = done && ie;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        latch     = 1'b0;
        advance   = 1'b0;
        set_done  = 1'b0;
        eng_en    = 1'b0;
        eng_we    = 2'b00;
        eng_addr  = 14'h0;
        eng_din   = 16'h0;
        case (state)
            ST_IDLE: begin
                if (start_req && !abort_req) begin
                    if (cnt_reg != 16'h0) begin
                        load      = 1'b1;
                        state_nxt = ST_RD;
                    end else begin
                        set_done  = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (!per_en) begin
                    eng_en    = 1'b1;
                    eng_addr  = src_ptr[14:1];
                    latch     = 1'b1;
                    state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                if (!per_en) begin
                    eng_en    = 1'b1;
                    eng_we    = 2'b11;
                    eng_addr  = dst_ptr[14:1];
                    eng_din   = data_q;
                    advance   = 1'b1;
                    if (cnt_reg == 16'h1) begin
                        set_done  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // ABORT only arrives on a CPU cycle, so no engine bus cycle is live here.
        if (abort_req) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
            set_done  = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            src_reg <= 16'h0;
            dst_reg <= 16'h0;
            cnt_reg <= 16'h0;
            src_ptr <= 16'h0;
            dst_ptr <= 16'h0;
            data_q  <= 16'h0;
            done    <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (reg_wr && !busy && sel_src) src_reg <= per_din;
            if (reg_wr && !busy && sel_dst) dst_reg <= per_din;
            if (reg_wr && !busy && sel_cnt) cnt_reg <= per_din;
            if (ctrl_wr)                    ie      <= per_din[3];
            if (load) begin
                src_ptr <= src_reg;
                dst_ptr <= dst_reg;
            end
            if (latch) data_q <= m_rdata;
            // CNT doubles as the remaining-word counter.
            if (advance) begin
                src_ptr <= src_ptr + 16'd2;
                dst_ptr <= dst_ptr + 16'd2;
                cnt_reg <= cnt_reg - 16'd1;
            end
            if (set_done)                   done <= 1'b1;
            else if (ctrl_wr && per_din[2]) done <= 1'b0;
        end
    end

    always_comb begin
        per_dout = 16'h0;
        if (reg_rd && !puc_rst) begin
            if (sel_ctrl) per_dout = {12'h0, ie, done, busy, 1'b0};
            if (sel_src)  per_dout = src_reg;
            if (sel_dst)  per_dout = dst_reg;
            if (sel_cnt)  per_dout = cnt_reg;
        end
    end

    always_comb begin
        if (puc_rst || per_en) begin
            m_addr = per_addr;
            m_din  = per_din;
            m_en   = per_en;
            m_we   = per_we;
        end else begin
            m_addr = eng_addr;
            m_din  = eng_din;
            m_en   = eng_en;
            m_we   = eng_we;
        end
    end

endmodule

// File: tb/tb_per_copy_engine.sv
// Self-checking bench for per_copy_engine: directed scenarios plus randomized copies with
// random CPU interference, checked against a word-copy reference model.
module tb_per_copy_engine;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [13:0] m_addr;
    logic [15:0] m_din;
    logic        m_en;
    logic [1:0]  m_we;
    logic [15:0] m_rdata;
    logic        irq;

    typedef struct packed {
        logic [13:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } bus_t;

    logic [15:0] mem [0:16383];
    bus_t        trace[$];
    logic [15:0] exp_data[$];
    int          n_cmp = 0;
    int          n_err = 0;

    per_copy_engine dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
        .per_dout(per_dout),
        .m_addr(m_addr), .m_din(m_din), .m_en(m_en), .m_we(m_we), .m_rdata(m_rdata),
        .irq(irq)
    );

    always #5 mclk = ~mclk;

    assign m_rdata = (m_en && m_we == 2'b00) ? mem[m_addr] : 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: CPU cycles must be mirrored, engine cycles are logged and applied to memory.
    always @(negedge mclk) begin
        if (!puc_rst) begin
            if (per_en) begin
                check("mirror_en", m_en, 1'b1);
                check("mirror_addr", m_addr, per_addr);
                check("mirror_we", m_we, per_we);
                check("mirror_din", m_din, per_din);
            end else if (m_en) begin
                bus_t e;
                e.addr = m_addr;
                e.we   = m_we;
                e.din  = m_din;
                trace.push_back(e);
                if (m_we == 2'b11) mem[m_addr] = m_din;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic cpu_cycle(input logic [15:0] byte_addr, input logic [1:0] we,
                             input logic [15:0] din, output logic [15:0] rd);
        per_en   = 1'b1;
        per_addr = byte_addr[14:1];
        per_we   = we;
        per_din  = din;
        #1 rd = per_dout;
        @(posedge mclk);
        #1;
        per_en   = 1'b0;
        per_addr = 14'h0;
        per_we   = 2'b00;
        per_din  = 16'h0;
    endtask

    task automatic wr(input logic [15:0] byte_addr, input logic [15:0] data);
        logic [15:0] unused;
        cpu_cycle(byte_addr, 2'b11, data, unused);
    endtask

    task automatic rd_check(input string tag, input logic [15:0] byte_addr, input logic [15:0] exp);
        logic [15:0] v;
        cpu_cycle(byte_addr, 2'b00, 16'h0, v);
        check(tag, v, exp);
    endtask

    task automatic wait_irq(input int limit, output int cycles);
        cycles = 0;
        while (!irq && cycles < limit) begin
            tick(1);
            cycles++;
        end
        if (!irq) check("irq_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_trace(input int k, input int limit);
        int c = 0;
        while (trace.size() < k && c < limit) begin
            tick(1);
            c++;
        end
        if (trace.size() < k) check("trace_timeout", trace.size(), k);
    endtask

    // Snapshot source words into exp_data and clear the bus log before a transfer starts.
    task automatic prepare(input logic [15:0] src, input int n);
        logic [15:0] a;
        exp_data.delete();
        trace.delete();
        for (int i = 0; i < n; i++) begin
            a = src + 16'(2 * i);
            exp_data.push_back(mem[a[14:1]]);
        end
    endtask

    // Reference: word i is read from src+2i then written to dst+2i (16-bit byte-address wrap).
    task automatic check_copy(input string tag, input logic [15:0] src, input logic [15:0] dst,
                              input int n);
        logic [15:0] sa, da;
        check({tag, "_len"}, trace.size(), 2 * n);
        if (trace.size() == 2 * n) begin
            for (int i = 0; i < n; i++) begin
                sa = src + 16'(2 * i);
                da = dst + 16'(2 * i);
                check({tag, "_rd"}, {trace[2*i].addr, trace[2*i].we}, {sa[14:1], 2'b00});
                check({tag, "_wr"}, {trace[2*i+1].addr, trace[2*i+1].we, trace[2*i+1].din},
                      {da[14:1], 2'b11, exp_data[i]});
                check({tag, "_mem"}, mem[da[14:1]], exp_data[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, stalls;
        logic [15:0] src, dst, v;
        int          n;

        for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
        puc_rst = 1'b1;
        per_en = 1'b0; per_addr = 14'h0; per_we = 2'b00; per_din = 16'h0;
        tick(3);
        puc_rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_irq", irq, 1'b0);
        check("rst_m_en", m_en, 1'b0);
        rd_check("rst_ctrl", 16'h118, 16'h0);
        rd_check("rst_src", 16'h11A, 16'h0);
        rd_check("rst_dst", 16'h11C, 16'h0);
        rd_check("rst_cnt", 16'h11E, 16'h0);

        // Two-word copy with no CPU traffic
        mem[14'h88] = 16'hA5A5;
        mem[14'h89] = 16'h005A;
        wr(16'h11A, 16'h0110);
        wr(16'h11C, 16'h0120);
        wr(16'h11E, 16'h0002);
        prepare(16'h0110, 2);
        wr(16'h118, 16'h0009);
        wait_irq(50, cyc);
        check("basic_latency", cyc, 4);
        check_copy("basic", 16'h0110, 16'h0120, 2);
        check("basic_irq", irq, 1'b1);
        rd_check("basic_ctrl", 16'h118, 16'h000C);
        rd_check("basic_cnt", 16'h11E, 16'h0000);
        wr(16'h118, 16'h0004);
        check("basic_irq_clr", irq, 1'b0);

        // Same copy with a 3-cycle CPU burst after the first read
        mem[14'h88] = 16'($urandom);
        mem[14'h89] = 16'($urandom);
        wr(16'h11E, 16'h0002);
        prepare(16'h0110, 2);
        wr(16'h118, 16'h0009);
        tick(1);
        for (int i = 0; i < 3; i++) cpu_cycle(16'h0300 + 16'(2 * i), 2'b00, 16'h0, v);
        wait_irq(50, cyc);
        check("stall_latency", 4 + cyc, 7);
        check_copy("stall", 16'h0110, 16'h0120, 2);
        wr(16'h118, 16'h0004);

        // Zero count: DONE immediately, no engine cycles; set beats a same-cycle clear
        wr(16'h11E, 16'h0000);
        trace.delete();
        wr(16'h118, 16'h0009);
        check("zero_irq", irq, 1'b1);
        rd_check("zero_ctrl", 16'h118, 16'h000C);
        tick(3);
        check("zero_no_bus", trace.size(), 0);
        wr(16'h118, 16'h000D);
        rd_check("zero_set_wins", 16'h118, 16'h000C);
        wr(16'h118, 16'h0004);
        rd_check("zero_cleared", 16'h118, 16'h0000);

        // Writes while busy ignored; ABORT after two words
        for (int i = 0; i < 5; i++) mem[14'hA0 + 14'(i)] = 16'($urandom);
        for (int i = 0; i < 5; i++) mem[14'hB0 + 14'(i)] = 16'h0;
        wr(16'h11A, 16'h0140);
        wr(16'h11C, 16'h0160);
        wr(16'h11E, 16'h0005);
        prepare(16'h0140, 5);
        wr(16'h118, 16'h0009);
        wr(16'h11A, 16'h0200);
        cpu_cycle(16'h0118, 2'b01, 16'h0010, v);
        wait_trace(4, 50);
        wr(16'h118, 16'h0010);
        rd_check("abort_ctrl", 16'h118, 16'h0000);
        rd_check("abort_cnt", 16'h11E, 16'h0003);
        rd_check("abort_src", 16'h11A, 16'h0140);
        tick(4);
        check("abort_no_bus", trace.size(), 4);
        check("abort_rd0", trace[0].addr, 14'hA0);
        check("abort_w0", mem[14'hB0], exp_data[0]);
        check("abort_w1", mem[14'hB1], exp_data[1]);
        check("abort_w2", mem[14'hB2], 16'h0);

        // Randomized copies with random CPU interference
        for (int it = 0; it < 8; it++) begin
            n   = $urandom_range(1, 8);
            src = 16'($urandom_range(16'h0800, 16'h0FF0)) & 16'hFFFE;
            dst = src + 16'h2000;
            for (int i = 0; i < n; i++) begin
                v = src + 16'(2 * i);
                mem[v[14:1]] = 16'($urandom);
            end
            wr(16'h11A, src);
            wr(16'h11C, dst);
            wr(16'h11E, 16'(n));
            prepare(src, n);
            wr(16'h118, 16'h0009);
            cyc = 0;
            stalls = 0;
            while (!irq && cyc < 200) begin
                if ($urandom_range(3) == 0) begin
                    cpu_cycle(16'h6000 + 16'($urandom_range(255) * 2), 2'($urandom_range(3)),
                              16'($urandom), v);
                    stalls++;
                end else begin
                    tick(1);
                end
                cyc++;
            end
            check("rand_latency", cyc, 2 * n + stalls);
            check_copy("rand", src, dst, n);
            wr(16'h118, 16'h0004);
        end

        // Source pointer wrap, then reset during the second write
        mem[14'h3FFF] = 16'($urandom);
        mem[14'h0000] = 16'($urandom);
        wr(16'h11A, 16'hFFFE);
        wr(16'h11C, 16'h0180);
        wr(16'h11E, 16'h0002);
        prepare(16'hFFFE, 2);
        wr(16'h118, 16'h0009);
        wait_trace(3, 50);
        check("wrap_rd0", trace[0].addr, 14'h3FFF);
        check("wrap_rd1", trace[2].addr, 14'h0000);
        check("wrap_w0", mem[14'hC0], exp_data[0]);
        puc_rst = 1'b1;
        #1;
        check("rst_mid_m_en", m_en, 1'b0);
        rd_check("rst_mid_dout", 16'h011E, 16'h0);
        tick(1);
        puc_rst = 1'b0;
        tick(2);
        check("rst_mid_no_bus", trace.size(), 3);
        check("rst_mid_irq", irq, 1'b0);
        rd_check("rst_mid_ctrl", 16'h118, 16'h0);
        rd_check("rst_mid_src", 16'h11A, 16'h0);
        rd_check("rst_mid_dst", 16'h11C, 16'h0);
        rd_check("rst_mid_cnt", 16'h11E, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
